regfile_scoreboard: RTL

Architectural register file for the 5-stage MIPS pipeline: the receiving end of the writeback stage's `regwriteW`/`rdW`/`resultW` outputs. It holds 32×32-bit registers and provides two decode-stage read ports with same-cycle writeback bypass. A per-register pending-write scoreboard is incremented when decode issues a register-writing instruction and decremented when writeback retires it. The scoreboard drives a read-after-write stall to decode.

---
 rtl/regfile_scoreboard.sv | 82 ++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// Architectural register file (32 x DATA_W) with writeback bypass and a
// per-register pending-write scoreboard that raises a read-after-write stall to decode.
module regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        rs1D,
    input  logic [4:0]        rs2D,
    output logic [DATA_W-1:0] rd1D,
    output logic [DATA_W-1:0] rd2D,
    input  logic              issue_valid,
    input  logic              issue_regwrite,
    input  logic [4:0]        issue_rd,
    input  logic              regwriteW,
    input  logic [4:0]        rdW,
    input  logic [DATA_W-1:0] resultW,
    output logic              stallD,
    output logic              sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] regs [32];
    logic [CNT_W-1:0]  pend [32];

    logic        wbClr;
    logic        issueWr;
    logic        ovfAttempt;
    logic        busy1;
    logic        busy2;
    logic        accIssue;
    logic        underflow;
    logic [31:0] incVec;
    logic [31:0] decVec;

    always_comb begin
        rd1D = '0;
        rd2D = '0;
        if (rs1D != 5'd0) rd1D = (regwriteW && rdW == rs1D) ? resultW : regs[rs1D];
        if (rs2D != 5'd0) rd2D = (regwriteW && rdW == rs2D) ? resultW : regs[rs2D];
    end

    // A source is busy if its pending count stays nonzero after this cycle's retire.
    always_comb begin
        wbClr      = regwriteW && (rdW != 5'd0);
        issueWr    = issue_valid && issue_regwrite && (issue_rd != 5'd0);
        busy1      = (rs1D != 5'd0) && (pend[rs1D] != '0)
                     && !(wbClr && rdW == rs1D && pend[rs1D] == CNT_ONE);
        busy2      = (rs2D != 5'd0) && (pend[rs2D] != '0)
                     && !(wbClr && rdW == rs2D && pend[rs2D] == CNT_ONE);
        ovfAttempt = issueWr && (pend[issue_rd] == CNT_MAX)
                     && !(wbClr && rdW == issue_rd);
        stallD     = busy1 || busy2 || ovfAttempt;
        accIssue   = issueWr && !stallD;
        underflow  = wbClr && (pend[rdW] == '0);
        incVec     = accIssue ? (32'd1 << issue_rd) : '0;
        decVec     = wbClr ? (32'd1 << rdW) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
                pend[i] <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            if (wbClr) regs[rdW] <= resultW;
            for (int unsigned i = 0; i < 32; i++) begin
                if (incVec[i] && !decVec[i])
                    pend[i] <= pend[i] + CNT_ONE;
                else if (decVec[i] && !incVec[i] && pend[i] != '0)
                    pend[i] <= pend[i] - CNT_ONE;
            end
            if (ovfAttempt || underflow) sb_err <= 1'b1;
        end
    end

endmodule
